// File: rtl/convex_pkg.sv
// Shared types and constants for the CONVEX feeder.
// Point bundle, FSM states and a saturating drop accumulator.
package convex_pkg;

  localparam int COORD_W = 10;
  localparam int PTNUM_W = 9;
  localparam int DROP_W  = 7;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  function automatic logic [PTNUM_W-1:0] sat_add(
    input logic [PTNUM_W-1:0] a,
    input logic [DROP_W-1:0]  b
  );
    logic [PTNUM_W:0] s;
    s = {1'b0, a} + {{(PTNUM_W+1-DROP_W){1'b0}}, b};
    return s[PTNUM_W] ? '1 : s[PTNUM_W-1:0];
  endfunction

endpackage

// File: rtl/convex_pt_fifo.sv
// Synchronous point FIFO with registered full/empty flags.
// Ports: i_push/i_pop/i_flush, i_data in, o_data head, o_full, o_empty.
module convex_pt_fifo
  import convex_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  point_t i_data,
  output point_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  point_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !r_full && !i_flush;
  assign w_pop   = i_pop && !r_empty && !i_flush;
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + (AW+1)'(1);
      2'b01:   w_cnt_nxt = r_cnt - (AW+1)'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
    if (i_flush) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (i_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/convex_feeder.sv
// Feeds buffered points to CONVEX one at a time, sums drop counts.
// Ports: src_* host stream, busy/done/err/total_drop status, CONVEX i/f.
module convex_feeder
  import convex_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src_start,
  input  logic [PTNUM_W-1:0] src_pt_num,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PTNUM_W-1:0] total_drop,
  output logic               in_valid,
  output logic [PTNUM_W-1:0] pt_num,
  output logic [COORD_W-1:0] in_x,
  output logic [COORD_W-1:0] in_y,
  input  logic               out_valid,
  input  logic [DROP_W-1:0]  drop_num
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_nxt;
  logic [PTNUM_W-1:0] r_n, w_n_nxt;
  logic [PTNUM_W-1:0] r_issued, w_issued_nxt;
  logic [PTNUM_W-1:0] r_total, w_total_nxt;
  logic [TW-1:0]      r_tmo, w_tmo_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               r_in_valid, w_in_valid_nxt;
  logic [PTNUM_W-1:0] r_pt_num, w_pt_num_nxt;
  logic [COORD_W-1:0] r_in_x, w_in_x_nxt;
  logic [COORD_W-1:0] r_in_y, w_in_y_nxt;
  logic               w_pop;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  point_t             w_head;
  point_t             w_src_pt;

  assign w_src_pt.x = src_x;
  assign w_src_pt.y = src_y;

  convex_pt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (src_valid),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_src_pt),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign src_ready  = !w_full;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign total_drop = r_total;
  assign in_valid   = r_in_valid;
  assign pt_num     = r_pt_num;
  assign in_x       = r_in_x;
  assign in_y       = r_in_y;

  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_issued_nxt   = r_issued;
    w_total_nxt    = r_total;
    w_tmo_nxt      = r_tmo;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_in_valid_nxt = 1'b0;
    w_pt_num_nxt   = '0;
    w_in_x_nxt     = '0;
    w_in_y_nxt     = '0;
    w_pop          = 1'b0;
    w_flush        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (src_start && (src_pt_num != '0)) begin
          w_n_nxt      = src_pt_num;
          w_total_nxt  = '0;
          w_issued_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_in_valid_nxt = 1'b1;
          w_in_x_nxt     = w_head.x;
          w_in_y_nxt     = w_head.y;
          if (r_issued == '0) w_pt_num_nxt = r_n;
          w_issued_nxt   = r_issued + PTNUM_W'(1);
          w_tmo_nxt      = '0;
          w_state_nxt    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (out_valid) begin
          w_total_nxt = sat_add(r_total, drop_num);
          w_state_nxt = WAIT_LO;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_flush     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!out_valid) begin
          if (r_issued == r_n) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = ISSUE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_issued   <= '0;
      r_total    <= '0;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_in_valid <= 1'b0;
      r_pt_num   <= '0;
      r_in_x     <= '0;
      r_in_y     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_issued   <= w_issued_nxt;
      r_total    <= w_total_nxt;
      r_tmo      <= w_tmo_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_in_valid <= w_in_valid_nxt;
      r_pt_num   <= w_pt_num_nxt;
      r_in_x     <= w_in_x_nxt;
      r_in_y     <= w_in_y_nxt;
    end
  end

endmodule

// File: tb/tb_convex_feeder.sv
// Scoreboard bench for convex_feeder with a simple CONVEX responder.
// Covers reset, bursts, FIFO wrap/backpressure, timeout and mid-set reset.
module tb_convex_feeder;

  logic       clk;
  logic       rst_n;
  logic       src_start;
  logic [8:0] src_pt_num;
  logic       src_valid;
  logic       src_ready;
  logic [9:0] src_x;
  logic [9:0] src_y;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] total_drop;
  logic       in_valid;
  logic [8:0] pt_num;
  logic [9:0] in_x;
  logic [9:0] in_y;
  logic       out_valid;
  logic [6:0] drop_num;

  convex_feeder #(.DEPTH(16), .TIMEOUT(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_start  (src_start),
    .src_pt_num (src_pt_num),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_x      (src_x),
    .src_y      (src_y),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .total_drop (total_drop),
    .in_valid   (in_valid),
    .pt_num     (pt_num),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .drop_num   (drop_num)
  );

  typedef struct {
    int x;
    int y;
    int n;
  } exp_pt_t;

  typedef struct {
    int is_err;
    int total;
  } exp_end_t;

  exp_pt_t  q_pt[$];
  exp_end_t q_end[$];
  logic [6:0] q_drop[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_inv = 0;
  int inv_cnt = 0;
  int resp_len = 1;
  bit no_resp = 0;

  int ax[4] = '{1, 5, 5, 1};
  int ay[4] = '{1, 1, 5, 5};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp_pt(input int x, input int y, input int n);
    exp_pt_t e;
    e.x = x;
    e.y = y;
    e.n = n;
    q_pt.push_back(e);
  endtask

  task automatic exp_end(input int is_err, input int total);
    exp_end_t e;
    e.is_err = is_err;
    e.total  = total;
    q_end.push_back(e);
  endtask

  task automatic push_pt(input int x, input int y);
    int c = 0;
    src_valid = 1'b1;
    src_x = 10'(x);
    src_y = 10'(y);
    @(negedge clk);
    while (!src_ready && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!src_ready) check("push_bound", 0, 1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  task automatic start_set(input int n);
    src_start = 1'b1;
    src_pt_num = 9'(n);
    @(posedge clk);
    #1;
    src_start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int c = 0;
    while ((q_end.size() != 0 || q_pt.size() != 0) && c < max) begin
      @(negedge clk);
      c++;
    end
    check("wait_end", q_end.size() + q_pt.size(), 0);
    q_end.delete();
    q_pt.delete();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_pt_t  p;
    exp_end_t e;
    if (rst_n) begin
      if (in_valid) begin
        inv_cnt++;
        last_inv = cyc;
        if (q_pt.size() == 0) begin
          check("unexp_in_valid", 1, 0);
        end else begin
          p = q_pt.pop_front();
          check("in_x", int'(in_x), p.x);
          check("in_y", int'(in_y), p.y);
          check("pt_num", int'(pt_num), p.n);
        end
      end else begin
        check("idle_zero", int'({pt_num, in_x, in_y}), 0);
      end
      if (done || err) begin
        if (q_end.size() == 0) begin
          check("unexp_end", int'({done, err}), 0);
        end else begin
          e = q_end.pop_front();
          check("end_kind", int'({done, err}), e.is_err ? 1 : 2);
          check("end_total", int'(total_drop), e.total);
          check("end_busy", int'(busy), 0);
          if (err) check("err_latency", cyc - last_inv, 1000);
        end
      end
    end
  end

  // CONVEX responder
  initial begin
    logic [6:0] d;
    out_valid = 1'b0;
    drop_num = '0;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && !no_resp) begin
        d = (q_drop.size() != 0) ? q_drop.pop_front() : 7'd0;
        @(posedge clk);
        #1;
        out_valid = 1'b1;
        drop_num = d;
        for (int k = 1; k < resp_len && rst_n; k++) begin
          @(posedge clk);
          #1;
          drop_num = 7'h55;
        end
        @(posedge clk);
        #1;
        out_valid = 1'b0;
        drop_num = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    src_start = 1'b0;
    src_pt_num = '0;
    src_valid = 1'b0;
    src_x = '0;
    src_y = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_ready", int'(src_ready), 1);
    check("rst_ctl", int'({done, err, in_valid, busy}), 0);
    check("rst_total", int'(total_drop), 0);
    check("rst_data", int'({pt_num, in_x, in_y}), 0);
    @(posedge clk);
    #1;

    start_set(0);
    @(negedge clk);
    check("zero_start_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // Square, single-cycle responses
    resp_len = 1;
    for (int i = 0; i < 4; i++) begin
      push_pt(ax[i], ay[i]);
      exp_pt(ax[i], ay[i], i == 0 ? 4 : 0);
      q_drop.push_back(7'd0);
    end
    exp_end(0, 0);
    src_start = 1'b1;
    src_pt_num = 9'd4;
    @(posedge clk);
    #1;
    src_start = 1'b0;
    @(negedge clk);
    check("lat1_in_valid", int'(in_valid), 0);
    check("lat1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat2_in_valid", int'(in_valid), 1);
    @(posedge clk);
    #1;
    wait_end(200);

    // Multi-cycle bursts, summed once each
    resp_len = 3;
    push_pt(10, 20);
    push_pt(30, 40);
    push_pt(50, 60);
    exp_pt(10, 20, 3);
    exp_pt(30, 40, 0);
    exp_pt(50, 60, 0);
    q_drop.push_back(7'd0);
    q_drop.push_back(7'd2);
    q_drop.push_back(7'd1);
    exp_end(0, 3);
    start_set(3);
    repeat (4) @(posedge clk);
    #1;
    start_set(1);
    wait_end(300);

    // Fill, backpressure, wrap-around, saturation
    resp_len = 1;
    for (int i = 0; i < 20; i++) begin
      exp_pt(i, 200 + i, i == 0 ? 20 : 0);
      q_drop.push_back(7'd100);
    end
    exp_end(0, 511);
    for (int i = 0; i < 16; i++) push_pt(i, 200 + i);
    @(negedge clk);
    check("full_ready", int'(src_ready), 0);
    @(posedge clk);
    #1;
    start_set(20);
    c = 0;
    @(negedge clk);
    while (!in_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("first_pop_seen", int'(in_valid), 1);
    check("ready_after_pop", int'(src_ready), 1);
    @(posedge clk);
    #1;
    for (int i = 16; i < 20; i++) push_pt(i, 200 + i);
    wait_end(500);

    // Timeout with flush
    no_resp = 1'b1;
    push_pt(300, 301);
    push_pt(302, 303);
    push_pt(304, 305);
    exp_pt(300, 301, 3);
    exp_end(1, 0);
    start_set(3);
    wait_end(1200);
    check("tmo_busy", int'(busy), 0);
    no_resp = 1'b0;
    resp_len = 1;
    push_pt(7, 7);
    exp_pt(7, 7, 1);
    q_drop.push_back(7'd9);
    exp_end(0, 9);
    start_set(1);
    wait_end(200);

    // Reset during WAIT_LO of the second point
    resp_len = 4;
    for (int i = 0; i < 5; i++) begin
      push_pt(400 + i, 410 + i);
      exp_pt(400 + i, 410 + i, i == 0 ? 5 : 0);
      q_drop.push_back(i == 0 ? 7'd5 : 7'd1);
    end
    exp_end(0, 9);
    c = inv_cnt;
    start_set(5);
    for (int k = 0; k < 100 && inv_cnt < c + 2; k++) @(negedge clk);
    check("second_issue_seen", inv_cnt - c, 2);
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_total", int'(total_drop), 6);
    #2;
    q_pt.delete();
    q_end.delete();
    q_drop.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", int'({done, err, in_valid, busy}), 0);
    check("mid_rst_total", int'(total_drop), 0);
    check("mid_rst_data", int'({pt_num, in_x, in_y}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_ready", int'(src_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    resp_len = 2;
    push_pt(50, 60);
    push_pt(70, 80);
    exp_pt(50, 60, 2);
    exp_pt(70, 80, 0);
    q_drop.push_back(7'd3);
    q_drop.push_back(7'd4);
    exp_end(0, 7);
    start_set(2);
    wait_end(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
